// File: rtl/cpu_sequencer_pkg.sv
// seq_pkg: shared definitions for the multi-cycle RV32I control sequencer.
//   state_e    : 3-bit state encoding, also visible on the state output
//   OP_*       : RV32I major opcodes the sequencer recognises
//   op_class_e : 3-bit instruction class
//   op_classify: maps instruction[6:0] to its class
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Timeout counter width; covers MEM_TIMEOUT up to 255.
  localparam int unsigned TMO_W = 8;

  typedef enum logic [2:0] {
    OC_ALU     = 3'd0,
    OC_LOAD    = 3'd1,
    OC_STORE   = 3'd2,
    OC_BRANCH  = 3'd3,
    OC_JUMP    = 3'd4,
    OC_SYSTEM  = 3'd5,
    OC_ILLEGAL = 3'd6
  } op_class_e;

  function automatic op_class_e op_classify(input logic [6:0] op);
    op_class_e cls;
    case (op)
      OP_REG, OP_IMM, OP_LUI, OP_AUIPC: cls = OC_ALU;
      OP_LOAD:                          cls = OC_LOAD;
      OP_STORE:                         cls = OC_STORE;
      OP_BRANCH:                        cls = OC_BRANCH;
      OP_JAL, OP_JALR:                  cls = OC_JUMP;
      OP_SYSTEM:                        cls = OC_SYSTEM;
      default:                          cls = OC_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: control bundle between the sequencer and the datapath/memory.
//   master modport: sequencer side (drives strobes, requests, state, fault)
//   slave  modport: datapath/memory side (drives run, opcode, mem_ready)
// With SEQ_PERF_CNT_EN defined the bundle also carries cycle_cnt/instret_cnt.
interface cpu_sequencer_if;
  logic       run;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       imem_req;
  logic       ir_we;
  logic       dmem_req;
  logic       pc_we;
  logic       reg_we;
  logic       branch_en;
  logic [2:0] state;
  logic       fault;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;

  modport master (
    input  run, opcode, mem_ready,
    output imem_req, ir_we, dmem_req, pc_we, reg_we, branch_en, state, fault,
    output cycle_cnt, instret_cnt
  );
  modport slave (
    output run, opcode, mem_ready,
    input  imem_req, ir_we, dmem_req, pc_we, reg_we, branch_en, state, fault,
    input  cycle_cnt, instret_cnt
  );
`else
  modport master (
    input  run, opcode, mem_ready,
    output imem_req, ir_we, dmem_req, pc_we, reg_we, branch_en, state, fault
  );
  modport slave (
    output run, opcode, mem_ready,
    input  imem_req, ir_we, dmem_req, pc_we, reg_we, branch_en, state, fault
  );
`endif
endinterface

// File: rtl/cpu_sequencer_timeout_cnt.sv
// seq_timeout_cnt: memory-wait watchdog.
//   clk, rst  : clock, synchronous active-high reset
//   active    : sequencer is in a memory-wait state (FETCH or MEM)
//   mem_ready : memory access completes this cycle
//   expired   : MEM_TIMEOUT wait cycles have elapsed and memory is still not ready
// The count is held at zero outside the wait states, so every entry starts at 0.
module seq_timeout_cnt
  import seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic mem_ready,
  output logic expired
);

  localparam logic [TMO_W-1:0] LIMIT = TMO_W'(MEM_TIMEOUT);

  logic [TMO_W-1:0] count_q;
  logic [TMO_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (!active) begin
      count_d = '0;
    end else if (!mem_ready && (count_q != LIMIT)) begin
      count_d = count_q + TMO_W'(1);
    end
  end

  // mem_ready in the limit cycle takes priority over the timeout.
  always_comb begin
    expired = active && !mem_ready && (count_q == LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control for the RV32I
// datapath. Issues IR/PC/register-file strobes and memory requests, halts on a
// system opcode, faults on an illegal opcode or a memory-wait timeout.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : cpu_sequencer_if.master (run/opcode/mem_ready in, strobes out)
//   MEM_TIMEOUT : wait cycles tolerated before faulting (1..255)
// Define SEQ_PERF_CNT_EN to add the cycle_cnt/instret_cnt performance counters.
module cpu_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  cpu_sequencer_if.master       bus
);

  state_e    state_q;
  state_e    state_d;
  op_class_e cls;
  logic      tmo_active;
  logic      tmo_expired;

  assign cls        = op_classify(bus.opcode);
  assign tmo_active = (state_q == S_FETCH) || (state_q == S_MEM);

  seq_timeout_cnt #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .active   (tmo_active),
    .mem_ready(bus.mem_ready),
    .expired  (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_e retire_state;
    retire_state = bus.run ? S_FETCH : S_IDLE;
    state_d      = state_q;
    case (state_q)
      S_IDLE:   if (bus.run) state_d = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready)    state_d = S_DECODE;
        else if (tmo_expired) state_d = S_FAULT;
      end
      S_DECODE: begin
        case (cls)
          OC_SYSTEM:  state_d = S_HALT;
          OC_ILLEGAL: state_d = S_FAULT;
          default:    state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls)
          OC_LOAD, OC_STORE: state_d = S_MEM;
          OC_BRANCH:         state_d = retire_state;
          default:           state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ready)    state_d = (cls == OC_LOAD) ? S_WB : retire_state;
        else if (tmo_expired) state_d = S_FAULT;
      end
      S_WB:     state_d = retire_state;
      default:  state_d = state_q;
    endcase
  end

  // Strobes are suppressed in the reset cycle; fault reflects the state register.
  always_comb begin
    bus.imem_req  = 1'b0;
    bus.ir_we     = 1'b0;
    bus.dmem_req  = 1'b0;
    bus.pc_we     = 1'b0;
    bus.reg_we    = 1'b0;
    bus.branch_en = 1'b0;
    bus.fault     = (state_q == S_FAULT);
    bus.state     = state_q;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          bus.imem_req = 1'b1;
          bus.ir_we    = bus.mem_ready;
        end
        S_EXEC: begin
          bus.pc_we     = (cls == OC_BRANCH);
          bus.branch_en = (cls == OC_BRANCH);
        end
        S_MEM: begin
          bus.dmem_req = 1'b1;
          bus.pc_we    = bus.mem_ready && (cls == OC_STORE);
        end
        S_WB: begin
          bus.reg_we = 1'b1;
          bus.pc_we  = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instret_cnt_q, instret_cnt_d;

  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    if (!((state_q == S_IDLE) || (state_q == S_HALT) || (state_q == S_FAULT))) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end
    if (bus.pc_we) begin
      instret_cnt_d = instret_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign bus.cycle_cnt   = cycle_cnt_q;
  assign bus.instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Testbench for cpu_sequencer: directed per-cycle vectors are queued as
// expected state/strobe pairs; a negedge monitor pops and compares them.
module tb_cpu_sequencer;
  import seq_pkg::*;

  localparam logic [6:0] IM = 7'b1000000;  // imem_req
  localparam logic [6:0] IR = 7'b0100000;  // ir_we
  localparam logic [6:0] DM = 7'b0010000;  // dmem_req
  localparam logic [6:0] PC = 7'b0001000;  // pc_we
  localparam logic [6:0] RW = 7'b0000100;  // reg_we
  localparam logic [6:0] BR = 7'b0000010;  // branch_en
  localparam logic [6:0] FL = 7'b0000001;  // fault
  localparam logic [6:0] NO = 7'b0000000;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct {
    logic [2:0] st;
    logic [6:0] sb;
    string      nm;
  } exp_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  exp_t exp_q[$];

  cpu_sequencer_if bus ();

  cpu_sequencer #(
    .MEM_TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: act=no_finish req=finish");
    $fatal(1, "watchdog expired");
  end

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  initial begin
    exp_t       e;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {bus.imem_req, bus.ir_we, bus.dmem_req, bus.pc_we,
               bus.reg_we, bus.branch_en, bus.fault};
        checks++;
        if (bus.state !== e.st || act !== e.sb) begin
          errors++;
          $display("FAIL %s: act state=%0d strobes=%b req state=%0d strobes=%b",
                   e.nm, bus.state, act, e.st, e.sb);
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic [6:0] op, input logic rdy,
                     input logic [2:0] st, input logic [6:0] sb, input string nm);
    exp_t e;
    bus.run       = r;
    bus.opcode    = op;
    bus.mem_ready = rdy;
    e.st = st;
    e.sb = sb;
    e.nm = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst           = 1'b1;
    bus.run       = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: act=%0d req=%0d", nm, act, req);
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst           = 1'b1;
    bus.run       = 1'b0;
    bus.opcode    = '0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset_dut();
    cyc(0, OP_REG, 0, S_IDLE, NO, "reset_idle");

    // ALU, zero-wait: 4 cycles FETCH..WB, then back to FETCH
    cyc(1, OP_REG, 0, S_IDLE,   NO,      "alu_idle");
    cyc(1, OP_REG, 1, S_FETCH,  IM | IR, "alu_fetch");
    cyc(1, OP_REG, 1, S_DECODE, NO,      "alu_decode");
    cyc(1, OP_REG, 1, S_EXEC,   NO,      "alu_exec");
    cyc(1, OP_REG, 1, S_WB,     RW | PC, "alu_wb");

    // Load with 3 MEM wait cycles: 8 cycles total
    cyc(1, OP_LOAD, 1, S_FETCH,  IM | IR, "ld_fetch");
    cyc(1, OP_LOAD, 0, S_DECODE, NO,      "ld_decode");
    cyc(1, OP_LOAD, 0, S_EXEC,   NO,      "ld_exec");
    for (int i = 0; i < 3; i++) cyc(1, OP_LOAD, 0, S_MEM, DM, "ld_mem_wait");
    cyc(1, OP_LOAD, 1, S_MEM, DM,      "ld_mem_ready");
    cyc(1, OP_LOAD, 0, S_WB,  RW | PC, "ld_wb");

    // Branch retires from EXEC
    cyc(1, OP_BRANCH, 1, S_FETCH,  IM | IR, "br_fetch");
    cyc(1, OP_BRANCH, 0, S_DECODE, NO,      "br_decode");
    cyc(1, OP_BRANCH, 0, S_EXEC,   PC | BR, "br_exec");

    // Store retires on MEM ready; run low there returns to IDLE
    cyc(1, OP_STORE, 1, S_FETCH,  IM | IR, "st_fetch");
    cyc(1, OP_STORE, 0, S_DECODE, NO,      "st_decode");
    cyc(1, OP_STORE, 0, S_EXEC,   NO,      "st_exec");
    cyc(0, OP_STORE, 1, S_MEM,    DM | PC, "st_mem_retire");
    cyc(0, OP_STORE, 0, S_IDLE,   NO,      "st_idle");

    // JAL with run dropped mid-instruction still completes
    cyc(1, OP_JAL, 0, S_IDLE,   NO,      "jal_idle");
    cyc(0, OP_JAL, 1, S_FETCH,  IM | IR, "jal_fetch");
    cyc(0, OP_JAL, 0, S_DECODE, NO,      "jal_decode");
    cyc(0, OP_JAL, 0, S_EXEC,   NO,      "jal_exec");
    cyc(0, OP_JAL, 0, S_WB,     RW | PC, "jal_wb");
    cyc(0, OP_JAL, 0, S_IDLE,   NO,      "jal_idle_after");

    // 15 FETCH waits then ready in the limit cycle: no fault; system -> HALT
    cyc(1, OP_SYSTEM, 0, S_IDLE, NO, "tmo_ok_idle");
    for (int i = 0; i < 15; i++) cyc(1, OP_SYSTEM, 0, S_FETCH, IM, "tmo_ok_wait");
    cyc(1, OP_SYSTEM, 1, S_FETCH,  IM | IR, "tmo_ok_ready");
    cyc(1, OP_SYSTEM, 1, S_DECODE, NO,      "sys_decode");
    for (int i = 0; i < 20; i++) cyc(1, OP_SYSTEM, 1, S_HALT, NO, "halt_sticky");
    reset_dut();
    cyc(0, OP_SYSTEM, 0, S_IDLE, NO, "halt_cleared");

    // FETCH held not-ready: fault after 16 FETCH cycles
    cyc(1, OP_REG, 0, S_IDLE, NO, "tmo_idle");
    for (int i = 0; i < 16; i++) cyc(1, OP_REG, 0, S_FETCH, IM, "tmo_fetch_wait");
    for (int i = 0; i < 3; i++) cyc(1, OP_REG, 1, S_FAULT, FL, "fetch_fault_sticky");
    reset_dut();
    cyc(0, OP_REG, 0, S_IDLE, NO, "fault_cleared");

    // Illegal opcode
    cyc(1, OP_BAD, 0, S_IDLE,   NO,      "ill_idle");
    cyc(1, OP_BAD, 1, S_FETCH,  IM | IR, "ill_fetch");
    cyc(1, OP_BAD, 0, S_DECODE, NO,      "ill_decode");
    for (int i = 0; i < 3; i++) cyc(1, OP_BAD, 1, S_FAULT, FL, "ill_fault_sticky");
    reset_dut();
    cyc(0, OP_REG, 0, S_IDLE, NO, "ill_cleared");

    // MEM timeout on a load
    cyc(1, OP_LOAD, 0, S_IDLE,   NO,      "mtmo_idle");
    cyc(1, OP_LOAD, 1, S_FETCH,  IM | IR, "mtmo_fetch");
    cyc(1, OP_LOAD, 0, S_DECODE, NO,      "mtmo_decode");
    cyc(1, OP_LOAD, 0, S_EXEC,   NO,      "mtmo_exec");
    for (int i = 0; i < 16; i++) cyc(1, OP_LOAD, 0, S_MEM, DM, "mtmo_wait");
    cyc(1, OP_LOAD, 1, S_FAULT, FL, "mtmo_fault");
    reset_dut();

    // Reset while in MEM: no strobes in the reset cycle, IDLE afterwards
    cyc(1, OP_LOAD, 0, S_IDLE,   NO,      "rst_idle");
    cyc(1, OP_LOAD, 1, S_FETCH,  IM | IR, "rst_fetch");
    cyc(1, OP_LOAD, 0, S_DECODE, NO,      "rst_decode");
    cyc(1, OP_LOAD, 0, S_EXEC,   NO,      "rst_exec");
    rst = 1'b1;
    cyc(1, OP_LOAD, 1, S_MEM, NO, "rst_in_mem");
    rst = 1'b0;
    cyc(0, OP_LOAD, 0, S_IDLE, NO, "rst_mem_idle");

`ifdef SEQ_PERF_CNT_EN
    reset_dut();
    check32("cycle_cnt_reset",   bus.cycle_cnt,   32'd0);
    check32("instret_cnt_reset", bus.instret_cnt, 32'd0);
    cyc(1, OP_REG, 0, S_IDLE, NO, "perf_idle");
    for (int i = 0; i < 10; i++) begin
      cyc(1,       OP_REG, 1, S_FETCH,  IM | IR, "perf_fetch");
      cyc(1,       OP_REG, 0, S_DECODE, NO,      "perf_decode");
      cyc(1,       OP_REG, 0, S_EXEC,   NO,      "perf_exec");
      cyc(i < 9,   OP_REG, 0, S_WB,     RW | PC, "perf_wb");
    end
    check32("cycle_cnt_10alu",   bus.cycle_cnt,   32'd40);
    check32("instret_cnt_10alu", bus.instret_cnt, 32'd10);
    cyc(0, OP_REG, 0, S_IDLE, NO, "perf_end_idle");
`endif

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: act=%0d pending req=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the RV32I datapath built from the Controller, ALU and Decoder blocks. It steps each instruction through fetch, decode, execute, memory and writeback, and issues the write strobes (IR, PC, register file) and memory requests that the single-cycle blocks do not produce themselves. It guards every memory wait with a timeout. It halts on a system instruction and faults on an illegal opcode.

## Interface
- MEM_TIMEOUT, 15: maximum wait cycles for mem_ready before faulting (1..255)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  execution enable, sampled only in IDLE and at retire points
- opcode  in  7  instruction[6:0] from the IR, valid from DECODE onward
- mem_ready  in  1  instruction/data memory access complete this cycle
- imem_req  out  1  instruction fetch request, high throughout FETCH
- ir_we  out  1  IR load strobe
- dmem_req  out  1  data access request, high throughout MEM
- pc_we  out  1  PC update strobe (retire)
- reg_we  out  1  register-file write enable; gates the Controller's RegWrite
- branch_en  out  1  selects the branch-target path for the PC this cycle
- state  out  3  current state encoding
- fault  out  1  high while in FAULT

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
- IDLE: if run=1, go to FETCH.
- FETCH: imem_req=1.
  - When mem_ready=1: ir_we=1, then go to DECODE.
  - On timeout: go to FAULT.
- DECODE: classify the opcode.
  - 1110011 (system): go to HALT.
  - Not in {0000011, 0100011, 1100011, 1101111, 1100111, 0110011, 0010011, 0110111, 0010111}: go to FAULT.
  - Otherwise: go to EXEC.
- EXEC:
  - Load or store: go to MEM.
  - Branch (1100011): pc_we=1 and branch_en=1 (retire).
  - All others: go to WB.
- MEM: dmem_req=1.
  - mem_ready with a load: go to WB.
  - mem_ready with a store: pc_we=1 (retire).
  - On timeout: go to FAULT.
- WB: reg_we=1 and pc_we=1 (retire).
- Retire: the next state is FETCH if run=1, else IDLE. Deasserting run mid-instruction lets the current instruction complete.
- HALT and FAULT are sticky until rst. All strobes are 0 in both.
- Timeout counter:
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle mem_ready=0 in those states.
  - Reaching MEM_TIMEOUT with mem_ready=0 causes FAULT.
  - mem_ready=1 in that same cycle wins, so no fault is raised.
- Only one of imem_req and dmem_req is ever high.

## Timing
- Reset values: state=IDLE, and every strobe, request, fault and counter is 0.
- State is registered. Strobes are combinational from state, mem_ready and opcode.
- ir_we and the store-retire pc_we fire in the same cycle as mem_ready.
- Cycle counts assume zero-wait memory, from entering FETCH to the retire cycle inclusive:
  - branch: 3
  - ALU, LUI, AUIPC, JAL, JALR: 4
  - store: 4
  - load: 5
- Each wait cycle adds 1.
- rst during any state: IDLE on the next edge, with no strobe in the reset cycle.

## Configuration
- SEQ_PERF_CNT_EN defined: adds two 32-bit output ports.
  - cycle_cnt increments every cycle the state is not IDLE, HALT or FAULT.
  - instret_cnt increments on every pc_we.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: both ports and their registers are absent. Sequencing is identical either way.

## Structure
- Shared package seq_pkg holds:
  - the 3-bit state encodings
  - the opcode constants listed above
  - a 3-bit op-class enum: ALU, LOAD, STORE, BRANCH, JUMP, SYSTEM, ILLEGAL
- Sub-module seq_timeout_cnt holds the clear/increment/expire counter, parameterised by MEM_TIMEOUT.
- Opcode classification is a function in seq_pkg.

## Test plan
- Reset, run=1, opcode=0110011, mem_ready=1 -> states 1,2,3,5. ir_we in cycle 1, reg_we and pc_we in cycle 4, then FETCH.
- opcode=0000011, mem_ready low for 3 MEM cycles -> dmem_req for 4 cycles, then WB. 8 cycles total from FETCH to retire.
- opcode=1100011 -> pc_we=1, branch_en=1 in EXEC and reg_we never asserted. opcode=0100011 -> pc_we on the MEM mem_ready with no WB.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=15 -> FAULT (state=7, fault=1). mem_ready=1 on the 15th wait -> no fault, DECODE.
- opcode=1110011 -> HALT, strobes 0 for 20 cycles. opcode=1111111 -> FAULT. rst clears both to IDLE.
- SEQ_PERF_CNT_EN: 10 back-to-back ALU instructions -> instret_cnt=10, cycle_cnt=40. Preload near 2^32-1 -> wraps to 0.
